// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: FSM state encoding,
// the PC value loaded on reset, and a word-alignment helper used when
// forming icache addresses.
package inst_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Instruction memory is word addressed; the two byte-offset bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Fetcher performance counters: instructions handed to decode, HOLD cycles
// spent behind a JALR stall, and flush requests. Counters update one cycle
// after the qualifying event, wrap at 2^32 and freeze while rdy_in is low.
// Ports: clk_in/rst_in/rdy_in, three one-bit increment strobes, three 32-bit counts.
module ifetch_perf_cnt (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  input  logic        i_flush_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (rdy_in) begin
      r_fetch_cnt <= r_fetch_cnt + {31'd0, i_fetch_inc};
      r_stall_cnt <= r_stall_cnt + {31'd0, i_stall_inc};
      r_flush_cnt <= r_flush_cnt + {31'd0, i_flush_inc};
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: IDLE issues a one-cycle icache request, FETCH waits
// for the response, HOLD presents the word to decode until it is issued.
// Latency: request one cycle after entering IDLE; start_decode one cycle
// after icache_valid. Backpressure: rdy_in low freezes all state; the decoder
// holds the instruction via issue_signal.
// Ports: clk_in, rst_in, rdy_in; ROB redirect (wrong_predicted, correct_pc);
// decoder side (next_pc, issue_signal, jalr_stall, start_decode, inst,
// inst_addr); icache side (icache_req, icache_addr, icache_valid, icache_data).
// Optional: define IFETCH_PERF_CNT_EN to add perf_fetch_cnt, perf_stall_cnt,
// perf_flush_cnt outputs.
module inst_fetcher
  import inst_fetcher_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        wrong_predicted,
  input  logic [31:0] correct_pc,
  input  logic [31:0] next_pc,
  input  logic        issue_signal,
  input  logic        jalr_stall,
  output logic        start_decode,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_discard;
  logic         r_start_decode;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_addr;
  logic         r_icache_req;
  logic [31:0]  r_icache_addr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= ST_IDLE;
      r_pc           <= RESET_PC;
      r_discard      <= 1'b0;
      r_start_decode <= 1'b0;
      r_inst         <= 32'd0;
      r_inst_addr    <= 32'd0;
      r_icache_req   <= 1'b0;
      r_icache_addr  <= 32'd0;
    end else if (rdy_in) begin
      r_icache_req <= 1'b0;
      if (wrong_predicted) begin
        r_pc           <= correct_pc;
        r_start_decode <= 1'b0;
        // A request still in flight must be swallowed before a new one may
        // go out. If the response lands in this same cycle it is simply
        // dropped here, leaving nothing outstanding.
        if (r_state == ST_FETCH && !icache_valid) begin
          r_discard <= 1'b1;
          r_state   <= ST_FETCH;
        end else begin
          r_discard <= 1'b0;
          r_state   <= ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_icache_req  <= 1'b1;
            r_icache_addr <= word_align(r_pc);
            r_state       <= ST_FETCH;
          end
          ST_FETCH: begin
            if (icache_valid) begin
              if (r_discard) begin
                // Stale response from before the redirect.
                r_discard <= 1'b0;
                r_state   <= ST_IDLE;
              end else begin
                r_inst         <= icache_data;
                r_inst_addr    <= r_pc;
                r_start_decode <= 1'b1;
                r_state        <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (issue_signal) begin
              r_pc           <= next_pc;
              r_start_decode <= 1'b0;
              r_state        <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign start_decode = r_start_decode;
  assign inst         = r_inst;
  assign inst_addr    = r_inst_addr;
  assign icache_req   = r_icache_req;
  assign icache_addr  = r_icache_addr;

`ifdef IFETCH_PERF_CNT_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  // Mirrors the FETCH->HOLD hand-off condition in the FSM above.
  assign w_fetch_inc = !wrong_predicted && (r_state == ST_FETCH) &&
                       icache_valid && !r_discard;
  assign w_stall_inc = (r_state == ST_HOLD) && jalr_stall;

  ifetch_perf_cnt u_perf_cnt (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .i_fetch_inc (w_fetch_inc),
    .i_stall_inc (w_stall_inc),
    .i_flush_inc (wrong_predicted),
    .o_fetch_cnt (perf_fetch_cnt),
    .o_stall_cnt (perf_stall_cnt),
    .o_flush_cnt (perf_flush_cnt)
  );
`else
  // jalr_stall only feeds the stall counter; it never affects fetch flow.
  logic w_unused_jalr;
  assign w_unused_jalr = jalr_stall;
`endif

endmodule
